// File: rtl/cmp_seq.sv
// Multi-cycle MSB-first magnitude comparator, D bits per cycle, signed or unsigned.
// Latency 1..W/D cycles (early exit on first differing digit); start ignored unless idle, never queued.
module cmp_seq #(
    parameter int W = 8,
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sgn,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         busy,
    output logic         done,
    output logic         eq,
    output logic         lt,
    output logic         gt
);
    localparam int ND = W / D;
    localparam int CW = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [W-1:0]  MSB_MASK = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] CNT_LOAD = CW'(ND - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  sx_q, sx_d;
    logic [W-1:0]  sy_q, sy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          eq_q, eq_d;
    logic          lt_q, lt_d;
    logic          gt_q, gt_d;
    logic [D-1:0]  dx, dy;

    assign dx = sx_q[W-1 -: D];
    assign dy = sy_q[W-1 -: D];

    always_comb begin
        state_d = state_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        cnt_d   = cnt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Flipping both MSBs maps two's-complement order onto unsigned order.
                    sx_d    = sgn ? (x ^ MSB_MASK) : x;
                    sy_d    = sgn ? (y ^ MSB_MASK) : y;
                    cnt_d   = CNT_LOAD;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (dx != dy) begin
                    gt_d    = (dx > dy);
                    lt_d    = (dx < dy);
                    state_d = DONE;
                end else if (cnt_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    sx_d  = sx_q << D;
                    sy_d  = sy_q << D;
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sx_q    <= '0;
            sy_q    <= '0;
            cnt_q   <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            cnt_q   <= cnt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign eq   = eq_q;
    assign lt   = lt_q;
    assign gt   = gt_q;

endmodule

// File: doc/cmp_seq.md
# cmp_seq

Parametrised, multi-cycle magnitude comparator for W-bit operands, evaluated MSB-first in D-bit digits per clock, with signed/unsigned mode and a start/busy/done handshake. It generalises the team's 2-bit combinational eq/lt/gt comparator to wide operands. It terminates early on the first differing digit, trading latency for area. It sits beside the ALU datapath, where a narrow per-cycle compare is cheaper than a full-width combinational one.

## Interface
- W, default 8: operand width in bits; must be a multiple of D and ≥ 2.
- D, default 2: digit width compared per cycle; 1 ≤ D ≤ W.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- sgn  in  1  mode: 1 = two's-complement compare, 0 = unsigned; sampled with start.
- x  in  W  operand A; sampled with start.
- y  in  W  operand B; sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; results valid from this cycle on.
- eq  out  1  x == y.
- lt  out  1  x < y, under the selected mode.
- gt  out  1  x > y, under the selected mode.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset value of every output and internal register is 0, including busy, done, eq, lt and gt.
- IDLE, start=1 at an edge:
  - Latch x and y into shift registers sx and sy.
  - If sgn=1, invert the MSB of both latched copies. Unsigned compare of the flipped values then equals signed compare.
  - Load the digit counter with W/D − 1.
  - Clear eq, lt and gt.
  - Go to RUN.
- RUN, each cycle: compare the top D bits of sx and sy as unsigned values.
  - Top digits differ: set gt = (dx > dy) and lt = (dx < dy); go to DONE.
  - Top digits equal and counter = 0: set eq = 1; go to DONE.
  - Otherwise: shift sx and sy left by D, decrement the counter, stay in RUN.
- DONE: done = 1 for exactly one cycle, then unconditionally go to IDLE.
- Exactly one of eq, lt or gt is 1 after any done.
- Results hold until the next accepted start clears them.
- start in RUN or DONE is ignored, not queued.
- x, y and sgn may change freely after the accepting edge without affecting the operation in flight.
- No arithmetic beyond D-bit unsigned compare and a counter of width clog2(W/D), minimum 1 bit.

## Timing
- Let E0 be the edge that samples start=1 in IDLE.
- busy rises after E0 and falls at the edge that enters DONE.
- Let k be the number of digits examined: k = index of the first differing digit counted from the MSB digit as 1, or k = W/D when the operands are equal.
- done is high in the cycle following edge E0+k.
- Latency: minimum 1 cycle (MSB digit differs); maximum W/D cycles (equal operands, or only the last digit differs).
- Throughput: after done, IDLE lasts at least one cycle. The earliest next accepting edge is E0+k+2.
- busy and done are never high together.
- Asynchronous rst mid-RUN or mid-DONE:
  - Returns to IDLE immediately; all outputs go to 0.
  - No done pulse is produced for the aborted operation.
- start held high at rst release: accepted at the first rising edge with rst low.
- D = W: degenerates to a single RUN cycle; latency is always 1.

## Test plan
- W=8, D=2, sgn=0, x=0xA5, y=0xA5 → busy for 4 cycles, then done with eq=1, lt=0, gt=0.
- W=8, D=2, x=0x80, y=0x7F:
  - sgn=0 → done 1 cycle after start with gt=1.
  - sgn=1 → done 1 cycle after start with lt=1 (−128 < 127).
- W=8, D=2, sgn=0, x=0x12, y=0x13 → done after 4 cycles with lt=1. Then x=0x40, y=0x12 → gt=1 after 1 cycle, with eq, lt and gt cleared while busy.
- Pulse start in RUN with different operands → ignored. Result matches the first operands, and only one done pulse occurs. Assert rst for 1 ns mid-RUN → all outputs 0 at once, FSM in IDLE, no done.
- Exhaustive: W=4 with D=1, D=2 and D=4, all 256 (x, y) pairs in both modes, compared against a behavioural model.
  - Check eq/lt/gt correctness and one-hotness.
  - Check that done occurs exactly k cycles after start.
